// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits answer combinationally; misses write back a dirty victim, then refill word-serially.
module data_cache #(
    parameter int LINE_ADDR_LEN = 2,
    parameter int SET_ADDR_LEN  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_gnt,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int WORDS   = 1 << LINE_ADDR_LEN;
    localparam int SETS    = 1 << SET_ADDR_LEN;

    typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

    state_t                    state;
    logic [31:0]               line_q [SETS][WORDS];
    logic [TAG_LEN-1:0]        tag_q  [SETS];
    logic [SETS-1:0]           valid_q;
    logic [SETS-1:0]           dirty_q;
    logic [LINE_ADDR_LEN-1:0]  cnt;
    logic [LINE_ADDR_LEN-1:0]  cnt_inc;
    logic [TAG_LEN-1:0]        req_tag;
    logic [SET_ADDR_LEN-1:0]   req_set;

    logic [LINE_ADDR_LEN-1:0]  word;
    logic [SET_ADDR_LEN-1:0]   set;
    logic [TAG_LEN-1:0]        tag;
    logic                      present;
    logic                      hit;
    logic                      victim_dirty;
    logic                      unused_byte_offset;

    assign word    = addr[LINE_ADDR_LEN+1:2];
    assign set     = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign tag     = addr[31:LINE_ADDR_LEN+SET_ADDR_LEN+2];
    assign unused_byte_offset = ^addr[1:0];

    assign present      = rd_req | wr_req;
    assign hit          = present & valid_q[set] & (tag_q[set] == tag);
    assign victim_dirty = valid_q[set] & dirty_q[set];
    assign cnt_inc      = cnt + LINE_ADDR_LEN'(1);

    // Simultaneous rd_req and wr_req is a store, so no load data is returned.
    assign rd_data = (state == IDLE && hit && rd_req && !wr_req) ? line_q[set][word] : 32'd0;
    assign miss    = rst_n & (((state == IDLE) & present & ~hit) | (state != IDLE));

    // Memory handshake: while mem_req is high, mem_we/mem_addr/mem_wdata describe the
    // current word and stay frozen until a cycle with mem_gnt=1 accepts (or returns) it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid_q   <= '0;
            dirty_q   <= '0;
            cnt       <= '0;
            req_tag   <= '0;
            req_set   <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                        if (wr_req) dirty_q[set] <= 1'b1;
                    end else if (present) begin
                        req_tag <= tag;
                        req_set <= set;
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                        if (victim_dirty) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_q[set], set, {LINE_ADDR_LEN{1'b0}}, 2'b00};
                            mem_wdata <= line_q[set][0];
                        end else begin
                            state     <= REFILL;
                            mem_we    <= 1'b0;
                            mem_addr  <= {tag, set, {LINE_ADDR_LEN{1'b0}}, 2'b00};
                        end
                    end
                end
                WB: begin
                    if (mem_gnt) begin
                        if (&cnt) begin
                            cnt       <= '0;
                            state     <= REFILL;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                            mem_addr  <= {req_tag, req_set, {LINE_ADDR_LEN{1'b0}}, 2'b00};
                        end else begin
                            cnt       <= cnt_inc;
                            mem_addr  <= {tag_q[req_set], req_set, cnt_inc, 2'b00};
                            mem_wdata <= line_q[req_set][cnt_inc];
                        end
                    end
                end
                REFILL: begin
                    if (mem_gnt) begin
                        if (&cnt) begin
                            cnt              <= '0;
                            state            <= IDLE;
                            mem_req          <= 1'b0;
                            mem_addr         <= '0;
                            valid_q[req_set] <= 1'b1;
                            dirty_q[req_set] <= 1'b0;
                        end else begin
                            cnt      <= cnt_inc;
                            mem_addr <= {req_tag, req_set, cnt_inc, 2'b00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag storage carry no reset; valid bits alone decide residency.
    always_ff @(posedge clk) begin
        if (state == IDLE && hit && wr_req)
            line_q[set][word] <= wr_data;
        if (state == REFILL && mem_gnt) begin
            line_q[req_set][cnt] <= mem_rdata;
            if (&cnt) tag_q[req_set] <= req_tag;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a memory model answers the word-serial handshake and
// a queue of expected memory transfers is checked as each word is granted.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        miss;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_gnt;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    logic [64:0] exp_q[$];
    logic [31:0] mem_model [128];

    always #5 clk = ~clk;

    data_cache dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .miss      (miss),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_gnt   (mem_gnt),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_refill(input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({1'b0, base + 32'(4 * i), 32'd0});
    endtask

    task automatic push_wb(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
        exp_q.push_back({1'b1, base,         d0});
        exp_q.push_back({1'b1, base + 32'd4,  d1});
        exp_q.push_back({1'b1, base + 32'd8,  d2});
        exp_q.push_back({1'b1, base + 32'd12, d3});
    endtask

    // Acts as memory until miss falls; optionally withholds gnt before refill word
    // stall_word for stall_n cycles, or returns early once abort_after refill words are in.
    task automatic serve(input int stall_word, input int stall_n, input int abort_after);
        int          refills = 0;
        int          held    = 0;
        bit          done    = 1'b0;
        logic [64:0] e;
        logic [6:0]  idx;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            #1;
            mem_gnt = 1'b0;
            if (!miss) begin
                done = 1'b1;
            end else if (abort_after >= 0 && refills == abort_after) begin
                done = 1'b1;
            end else begin
                check("mem_req_during_miss", 32'(mem_req), 32'd1);
                if (mem_req) begin
                    if (!mem_we && refills == stall_word && held < stall_n) begin
                        check("stall_addr", mem_addr, exp_q[0][63:32]);
                        check("stall_we", 32'(mem_we), 32'd0);
                        held++;
                    end else if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $error("FAIL tx_unexpected observed=%h expected=none", mem_addr);
                        mem_rdata = 32'd0;
                        mem_gnt   = 1'b1;
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_we", 32'(mem_we), 32'(e[64]));
                        check("tx_addr", mem_addr, e[63:32]);
                        if (e[64]) check("tx_wdata", mem_wdata, e[31:0]);
                        idx = mem_addr[8:2];
                        if (mem_we) begin
                            mem_model[idx] = mem_wdata;
                        end else begin
                            mem_rdata = mem_model[idx];
                            refills++;
                        end
                        mem_gnt = 1'b1;
                    end
                end
            end
        end
        if (!done) begin
            total++;
            bad++;
            $error("FAIL serve_timeout observed=stuck expected=miss_cleared");
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_model[i] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            mem_model[16 + i] = 32'hA0 + 32'(i);
            mem_model[80 + i] = 32'hB0 + 32'(i);
        end
        rst_n     = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        addr      = 32'd0;
        wr_data   = 32'd0;
        mem_rdata = 32'd0;
        mem_gnt   = 1'b0;

        @(negedge clk);
        #1;
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss on 0x40: refill only.
        @(negedge clk);
        rd_req = 1'b1;
        addr   = 32'h40;
        #1;
        check("cold_miss", 32'(miss), 32'd1);
        check("cold_rd_data", rd_data, 32'd0);
        push_refill(32'h40);
        serve(-1, 0, -1);
        check("cold_hit_data", rd_data, 32'hA0);
        check("cold_miss_cnt", miss_cnt, 32'd1);
        check("cold_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        check("cold_hit_cnt", hit_cnt, 32'd1);

        // Plain read hit.
        @(negedge clk);
        rd_req = 1'b1;
        addr   = 32'h48;
        #1;
        check("hit48_miss", 32'(miss), 32'd0);
        check("hit48_data", rd_data, 32'hA2);
        check("hit48_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        check("hit48_hit_cnt", hit_cnt, 32'd2);

        // Store hit then read back.
        @(negedge clk);
        wr_req  = 1'b1;
        addr    = 32'h44;
        wr_data = 32'hDEADBEEF;
        #1;
        check("st44_miss", 32'(miss), 32'd0);
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b1;
        #1;
        check("ld44_data", rd_data, 32'hDEADBEEF);
        check("ld44_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        check("st_ld_hit_cnt", hit_cnt, 32'd4);

        // Conflict miss on dirty set 0: writeback then refill.
        @(negedge clk);
        rd_req = 1'b1;
        addr   = 32'h140;
        #1;
        check("conflict_miss", 32'(miss), 32'd1);
        push_wb(32'h40, 32'hA0, 32'hDEADBEEF, 32'hA2, 32'hA3);
        push_refill(32'h140);
        serve(-1, 0, -1);
        check("conflict_hit_data", rd_data, 32'hB0);
        check("conflict_miss_cnt", miss_cnt, 32'd2);
        check("conflict_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        check("conflict_hit_cnt", hit_cnt, 32'd5);

        // Clean victim, refill stalled for 10 cycles before word 2.
        @(negedge clk);
        rd_req = 1'b1;
        addr   = 32'h44;
        #1;
        check("stall_miss_start", 32'(miss), 32'd1);
        push_refill(32'h40);
        serve(2, 10, -1);
        check("stall_hit_data", rd_data, 32'hDEADBEEF);
        check("stall_miss_cnt", miss_cnt, 32'd3);
        check("stall_q_empty", 32'(exp_q.size()), 32'd0);

        // Both requests high: treated as a store.
        @(negedge clk);
        wr_req  = 1'b1;
        addr    = 32'h48;
        wr_data = 32'h12345678;
        #1;
        check("both_rd_data", rd_data, 32'd0);
        check("both_miss", 32'(miss), 32'd0);
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        check("both_ld_data", rd_data, 32'h12345678);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        check("both_hit_cnt", hit_cnt, 32'd8);

        // Dirty conflict again; reset lands after two refill words.
        @(negedge clk);
        rd_req = 1'b1;
        addr   = 32'h140;
        #1;
        push_wb(32'h40, 32'hA0, 32'hDEADBEEF, 32'h12345678, 32'hA3);
        push_refill(32'h140);
        serve(-1, 0, 2);
        check("abort_miss_cnt", miss_cnt, 32'd4);
        rst_n = 1'b0;
        #1;
        check("abort_miss", 32'(miss), 32'd0);
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_miss_cnt_clr", miss_cnt, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        rd_req = 1'b0;

        // Everything invalid after reset: clean refill, no writeback.
        @(negedge clk);
        rd_req = 1'b1;
        addr   = 32'h40;
        #1;
        check("post_rst_miss", 32'(miss), 32'd1);
        push_refill(32'h40);
        serve(-1, 0, -1);
        check("post_rst_data", rd_data, 32'hA0);
        check("post_rst_miss_cnt", miss_cnt, 32'd1);
        check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rd_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
Direct-mapped, write-back, write-allocate data cache for the MEM stage of the pipelined RV32I core. It answers load/store hits combinationally in the same cycle. On a miss it raises miss, which is the DCacheMiss input of the hazard logic, and holds it until the line is resident. It services misses by writing back a dirty victim and then refilling the line over a word-serial memory handshake.

Parameters:
LINE_ADDR_LEN, 2, log2 of words per line (default 4 words/line).
SET_ADDR_LEN, 2, log2 of number of sets (default 4 sets).
Derived, not overridable: TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
rd_req  input  1  load request from MEM stage.
wr_req  input  1  store request from MEM stage.
addr  input  32  byte address; [1:0] ignored; word = [LINE_ADDR_LEN+1:2], set = next SET_ADDR_LEN bits, tag = remaining upper bits.
wr_data  input  32  store data, full word.
rd_data  output  32  load data, valid while rd_req and hit in IDLE.
miss  output  1  to hazard unit DCacheMiss; stalls the whole pipeline.
mem_req  output  1  memory transfer request.
mem_we  output  1  1 = writeback word, 0 = refill word.
mem_addr  output  32  word-aligned memory address.
mem_wdata  output  32  writeback word.
mem_rdata  input  32  refill word, valid with mem_gnt.
mem_gnt  input  1  one-cycle accept/return of the current word.
hit_cnt  output  32  count of serviced hit accesses.
miss_cnt  output  32  count of misses started.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all valid and dirty bits cleared; word counter=0; hit_cnt=miss_cnt=0; miss=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0. Data and tag arrays are not reset. rd_data is 0 when not a read hit.
- Request present = rd_req|wr_req. If both are high, the access is treated as a store.
- hit = present & valid[set] & (tag_array[set]==tag).
- miss = (state==IDLE & present & !hit) | (state!=IDLE). It is combinational with zero latency, as the hazard unit requires.
- States:
  - IDLE
    - Read hit: rd_data = line[set][word] in the same cycle.
    - Write hit: the word is written at the clock edge and dirty[set] is set to 1.
    - Each hit cycle increments hit_cnt at the edge. The counter saturates at 0xFFFFFFFF.
    - On a miss: latch the request tag and set, clear the word counter, increment miss_cnt (saturating). Go to WB if the victim is valid&dirty, else go to REFILL.
  - WB
    - Outputs: mem_req=1, mem_we=1, mem_addr={victim_tag,set,cnt,2'b00}, mem_wdata=line[set][cnt].
    - On mem_gnt: cnt+1. On the last word's gnt: cnt=0, go to REFILL.
  - REFILL
    - Outputs: mem_req=1, mem_we=0, mem_addr={req_tag,set,cnt,2'b00}.
    - On mem_gnt: line[set][cnt] = mem_rdata, cnt+1.
    - On the last word: tag = req_tag, valid=1, dirty=0, go to IDLE.
  - IDLE after refill: the still-stalled request now hits, and miss falls. A store writes its data and sets dirty in that cycle.
- mem_addr, mem_we and mem_wdata are held stable while mem_req=1 and mem_gnt=0. There is no timeout.
- If rd_req/wr_req drop mid-miss (e.g. a flush), the in-flight WB/REFILL still completes. miss stays 1 until IDLE is reached.
- Miss latency with 1-cycle gnt = 2^LINE_ADDR_LEN cycles, plus 2^LINE_ADDR_LEN more if dirty, plus 1 IDLE cycle.
- rst_n asserted mid-transfer aborts immediately: mem_req=0, all lines invalid. A partially refilled line is discarded.

Test Plan:
- Reset, then rd_req addr=0x40 (tag 1, set 0) → miss=1 in the same cycle, no WB. Refill reads 0x40/0x44/0x48/0x4C with mem_rdata 0xA0..0xA3 and 1-cycle gnt. The cycle after the last gnt: miss=0, rd_data=0xA0, miss_cnt=1, hit_cnt=1.
- rd_req 0x48 → rd_data=0xA2, miss=0, no mem_req, hit_cnt=2.
- wr_req 0x44 with wr_data=0xDEADBEEF, then rd_req 0x44 → rd_data=0xDEADBEEF, no mem_req.
- rd_req 0x140 (tag 5, set 0) → WB with mem_we=1 to 0x40..0x4C, data 0xA0, 0xDEADBEEF, 0xA2, 0xA3. Then REFILL from 0x140..0x14C, then hit; miss_cnt=2.
- During REFILL hold mem_gnt=0 for 10 cycles → mem_req, mem_addr and miss stay constant, cnt does not advance. Also set rd_req=wr_req=1 at 0x48 (hit) → treated as a store, rd_data=0, dirty set.
- rst_n=0 mid-REFILL → miss and mem_req are 0 immediately. A following rd_req 0x40 misses again with no WB, and miss_cnt restarts at 1.
